// File: rtl/cmn_pwm_gen_n_if.sv
// rtl/cmn_pwm_gen_n_if.sv - OPB register-bus bundle for the PWM generator
interface cmn_pwm_gen_n_if;
  logic        OPB_RE;
  logic        OPB_WE;
  logic [31:0] OPB_ADDR;
  logic [31:0] OPB_DI;
  logic [31:0] OPB_DO;

  modport master (
    output OPB_RE, OPB_WE, OPB_ADDR, OPB_DI,
    input  OPB_DO
  );

  modport slave (
    input  OPB_RE, OPB_WE, OPB_ADDR, OPB_DI,
    output OPB_DO
  );
endinterface

// File: rtl/cmn_pwm_gen_n.sv
// rtl/cmn_pwm_gen_n.sv - N-channel centre-aligned PWM with dead-time, shadowed reload and latched fault
module cmn_pwm_gen_n #(
  parameter int N_CH      = 6,
  parameter int CNT_W     = 12,
  parameter int DT_W      = 8,
  parameter int N_FLT     = 2,
  parameter int SYNC_STG  = 2,
  parameter int TEST_TICK = 16
) (
  input  logic             OPB_CLK,
  input  logic             OPB_RST_N,
  cmn_pwm_gen_n_if.slave   opb,
  output logic [N_CH-1:0]  pwm_hi_o,
  output logic [N_CH-1:0]  pwm_lo_o,
  output logic             en_o,
  input  logic [N_FLT-1:0] fault_i,
  output logic             fault_o
);

  localparam int RUN_W = 8 + $clog2(TEST_TICK + 1);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;

  logic [N_CH-1:0]               r_en_sh;
  logic [N_CH-1:0]               r_en_act;
  logic                          r_tm_sh;
  logic [7:0]                    r_dur_sh;
  logic [CNT_W-1:0]              r_per_sh;
  logic [CNT_W-1:0]              r_per_act;
  logic [DT_W-1:0]               r_dt;
  logic [CNT_W-1:0]              r_duty_sh  [N_CH];
  logic [CNT_W-1:0]              r_duty_act [N_CH];

  logic [CNT_W-1:0]              r_cnt;
  logic                          r_dn;
  logic [RUN_W-1:0]              r_run_cnt;
  logic                          r_lim;
  logic                          r_test_done;

  logic [SYNC_STG-1:0][N_FLT-1:0] r_sync;
  logic [N_FLT-1:0]              r_mask;
  logic                          r_fault;

  logic [N_CH-1:0]               r_raw;
  logic [DT_W-1:0]               r_len [N_CH];
  logic [N_CH-1:0]               r_hi;
  logic [N_CH-1:0]               r_lo;
  logic [31:0]                   r_do;

  logic [5:0]                    w_addr;
  logic                          w_wr_ctrl;
  logic                          w_start;
  logic                          w_stop;
  logic                          w_clr;
  logic [N_FLT-1:0]              w_sync;
  logic                          w_flt_any;
  logic                          w_run;
  logic                          w_go;
  logic                          w_valley;
  logic                          w_test_end;
  logic                          w_load;
  logic [CNT_W-1:0]              w_top;
  logic [CNT_W-1:0]              w_per_clamp;
  logic [N_CH-1:0]               w_raw;
  logic [N_CH-1:0]               w_gate;
  logic [DT_W-1:0]               w_len [N_CH];
  logic [31:0]                   w_rd;
  logic                          w_unused;

  assign w_addr      = opb.OPB_ADDR[5:0];
  assign w_wr_ctrl   = opb.OPB_WE & (w_addr == 6'h03);
  assign w_start     = w_wr_ctrl & opb.OPB_DI[0];
  assign w_stop      = w_wr_ctrl & opb.OPB_DI[1];
  assign w_clr       = w_wr_ctrl & opb.OPB_DI[2];
  assign w_sync      = r_sync[SYNC_STG-1];
  assign w_flt_any   = |w_sync;
  assign w_run       = (r_state == S_RUN);
  assign w_go        = (r_state == S_IDLE) && (w_state_nxt == S_RUN);
  // Period boundary: last cycle of the down-slope, so the new values apply from the first up-count 0
  assign w_valley    = w_run & r_dn & (r_cnt == '0);
  assign w_test_end  = w_valley & r_lim & (r_run_cnt == RUN_W'(1));
  assign w_load      = w_go | w_valley;
  assign w_top       = r_per_act - CNT_W'(1);
  assign w_per_clamp = (r_per_sh < CNT_W'(2)) ? CNT_W'(2) : r_per_sh;
  assign w_unused    = ^{opb.OPB_ADDR[31:6], opb.OPB_DI};

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && !w_stop && !r_fault && !w_flt_any) w_state_nxt = S_RUN;
      S_RUN:   if (w_stop || w_flt_any || w_test_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_en_sh  <= '0;
      r_tm_sh  <= 1'b0;
      r_dur_sh <= '0;
      r_per_sh <= '0;
      r_dt     <= '0;
      for (int i = 0; i < N_CH; i++) r_duty_sh[i] <= '0;
    end else if (opb.OPB_WE) begin
      case (w_addr)
        6'h00: begin
          r_en_sh  <= opb.OPB_DI[N_CH-1:0];
          r_tm_sh  <= opb.OPB_DI[16];
          r_dur_sh <= opb.OPB_DI[31:24];
        end
        6'h01: r_per_sh <= opb.OPB_DI[CNT_W-1:0];
        6'h02: r_dt     <= opb.OPB_DI[DT_W-1:0];
        default: begin
          for (int i = 0; i < N_CH; i++)
            if (w_addr == 6'(8 + i)) r_duty_sh[i] <= opb.OPB_DI[CNT_W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_en_act  <= '0;
      r_per_act <= '0;
      for (int i = 0; i < N_CH; i++) r_duty_act[i] <= '0;
    end else if (w_load) begin
      r_en_act  <= r_en_sh;
      r_per_act <= w_per_clamp;
      for (int i = 0; i < N_CH; i++) r_duty_act[i] <= r_duty_sh[i];
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_cnt <= '0;
      r_dn  <= 1'b0;
    end else if (!w_run || (w_state_nxt != S_RUN)) begin
      r_cnt <= '0;
      r_dn  <= 1'b0;
    end else if (!r_dn) begin
      if (r_cnt >= w_top) r_dn  <= 1'b1;
      else                r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      if (r_cnt == '0)    r_dn  <= 1'b0;
      else                r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_run_cnt   <= '0;
      r_lim       <= 1'b0;
      r_test_done <= 1'b0;
    end else if (w_go) begin
      r_lim       <= r_tm_sh & (r_dur_sh != '0);
      r_run_cnt   <= RUN_W'(r_dur_sh) * RUN_W'(TEST_TICK);
      r_test_done <= 1'b0;
    end else if (w_valley && r_lim) begin
      r_run_cnt <= r_run_cnt - RUN_W'(1);
      if (r_run_cnt == RUN_W'(1)) r_test_done <= 1'b1;
    end
  end

  // Clear only drops sources that are no longer asserted at the synchroniser output
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_sync  <= '0;
      r_mask  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], fault_i};
      if (w_clr) begin
        r_mask  <= w_sync;
        r_fault <= w_flt_any;
      end else begin
        r_mask  <= r_mask | w_sync;
        r_fault <= r_fault | w_flt_any;
      end
    end
  end

  always_comb begin
    w_raw  = '0;
    w_gate = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_len[i]  = '0;
      w_raw[i]  = w_run & r_en_act[i] & (r_cnt < r_duty_act[i]);
      w_gate[i] = w_run & r_en_act[i] & ~w_flt_any;
      // Run length of the current raw level, saturating at the dead-time
      if (w_raw[i] != r_raw[i])  w_len[i] = '0;
      else if (r_len[i] >= r_dt) w_len[i] = r_len[i];
      else                       w_len[i] = r_len[i] + DT_W'(1);
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_raw <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      for (int i = 0; i < N_CH; i++) r_len[i] <= '0;
    end else begin
      r_raw <= w_raw;
      for (int i = 0; i < N_CH; i++) begin
        r_len[i] <= w_len[i];
        r_hi[i]  <= w_gate[i] &  w_raw[i] & (w_len[i] >= r_dt);
        r_lo[i]  <= w_gate[i] & ~w_raw[i] & (w_len[i] >= r_dt);
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_addr)
      6'h00: begin
        w_rd[N_CH-1:0] = r_en_sh;
        w_rd[16]       = r_tm_sh;
        w_rd[31:24]    = r_dur_sh;
      end
      6'h01: w_rd[CNT_W-1:0] = r_per_sh;
      6'h02: w_rd[DT_W-1:0]  = r_dt;
      6'h04: begin
        w_rd[0]          = w_run;
        w_rd[1]          = r_fault;
        w_rd[2]          = r_test_done;
        w_rd[8 +: N_FLT] = r_mask;
      end
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (w_addr == 6'(8 + i)) w_rd[CNT_W-1:0] = r_duty_sh[i];
      end
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N)      r_do <= '0;
    else if (opb.OPB_RE) r_do <= w_rd;
  end

  assign opb.OPB_DO = r_do;
  assign pwm_hi_o   = r_hi;
  assign pwm_lo_o   = r_lo;
  assign en_o       = w_run & ~r_fault;
  assign fault_o    = r_fault;

endmodule

// File: tb/tb_cmn_pwm_gen_n.sv
// tb/tb_cmn_pwm_gen_n.sv - directed self-checking bench for cmn_pwm_gen_n
module tb_cmn_pwm_gen_n;
  localparam int N_CH  = 6;
  localparam int N_FLT = 2;

  logic             OPB_CLK;
  logic             OPB_RST_N;
  logic [N_FLT-1:0] fault_i;
  logic [N_CH-1:0]  pwm_hi_o;
  logic [N_CH-1:0]  pwm_lo_o;
  logic             en_o;
  logic             fault_o;

  int n_chk;
  int n_pass;

  cmn_pwm_gen_n_if u_opb ();

  cmn_pwm_gen_n #(
    .N_CH(N_CH), .CNT_W(12), .DT_W(8), .N_FLT(N_FLT), .SYNC_STG(2), .TEST_TICK(16)
  ) dut (
    .OPB_CLK  (OPB_CLK),
    .OPB_RST_N(OPB_RST_N),
    .opb      (u_opb),
    .pwm_hi_o (pwm_hi_o),
    .pwm_lo_o (pwm_lo_o),
    .en_o     (en_o),
    .fault_i  (fault_i),
    .fault_o  (fault_o)
  );

  initial begin
    OPB_CLK = 1'b0;
    forever #5 OPB_CLK = ~OPB_CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else             n_pass++;
  endtask

  task automatic opb_wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge OPB_CLK);
    u_opb.OPB_ADDR = addr;
    u_opb.OPB_DI   = data;
    u_opb.OPB_WE   = 1'b1;
    @(negedge OPB_CLK);
    u_opb.OPB_WE   = 1'b0;
  endtask

  task automatic opb_rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge OPB_CLK);
    u_opb.OPB_ADDR = addr;
    u_opb.OPB_RE   = 1'b1;
    @(negedge OPB_CLK);
    u_opb.OPB_RE   = 1'b0;
    data = u_opb.OPB_DO;
  endtask

  task automatic count_win(input int n, output int hi_c, output int lo_c,
                           output int off_c, output int both_c);
    hi_c = 0; lo_c = 0; off_c = 0; both_c = 0;
    repeat (n) begin
      @(negedge OPB_CLK);
      if (pwm_hi_o[0])                 hi_c++;
      if (pwm_lo_o[0])                 lo_c++;
      if (!pwm_hi_o[0] && !pwm_lo_o[0]) off_c++;
      if (pwm_hi_o[0] && pwm_lo_o[0])   both_c++;
    end
  endtask

  task automatic hi_pulse(output int len);
    int t;
    len = 0;
    t   = 0;
    @(negedge OPB_CLK);
    while (!pwm_hi_o[0] && t < 1000) begin @(negedge OPB_CLK); t++; end
    while (pwm_hi_o[0] && len < 1000) begin len++; @(negedge OPB_CLK); end
  endtask

  initial begin
    logic [31:0] rd;
    int hi_c, lo_c, off_c, both_c, len, t;

    n_chk = 0;
    n_pass = 0;
    OPB_RST_N      = 1'b0;
    fault_i        = '0;
    u_opb.OPB_RE   = 1'b0;
    u_opb.OPB_WE   = 1'b0;
    u_opb.OPB_ADDR = '0;
    u_opb.OPB_DI   = '0;

    repeat (3) @(negedge OPB_CLK);
    chk("rst_outs", {16'(pwm_hi_o), 8'(pwm_lo_o), 6'd0, en_o, fault_o}, 32'h0);
    chk("rst_do", u_opb.OPB_DO, 32'h0);
    OPB_RST_N = 1'b1;
    opb_rd(32'h04, rd); chk("rst_status", rd, 32'h0);

    // basic run: P=100, D0=30, DT=5
    opb_wr(32'h01, 32'd100);
    opb_wr(32'h08, 32'd30);
    opb_wr(32'h02, 32'd5);
    opb_wr(32'h00, 32'h1);
    opb_wr(32'h03, 32'h1);
    opb_rd(32'h04, rd); chk("run_status", rd, 32'h1);
    opb_rd(32'h01, rd); chk("period_rd", rd, 32'd100);
    opb_rd(32'h08, rd); chk("duty0_rd", rd, 32'd30);
    opb_rd(32'h3F, rd); chk("unmapped_rd", rd, 32'h0);
    opb_rd(32'h03, rd); chk("ctrl_rd", rd, 32'h0);
    repeat (400) @(negedge OPB_CLK);
    count_win(200, hi_c, lo_c, off_c, both_c);
    chk("t2_hi", hi_c, 55);
    chk("t2_lo", lo_c, 135);
    chk("t2_gap", off_c, 10);
    chk("t2_overlap", both_c, 0);
    chk("t2_ch_dis", {pwm_hi_o[N_CH-1:1], pwm_lo_o[N_CH-1:1]}, 0);

    // shadow duty: write just after a hi pulse ends
    t = 0;
    while (!pwm_hi_o[0] && t < 1000) begin @(negedge OPB_CLK); t++; end
    while (pwm_hi_o[0] && t < 2000) begin @(negedge OPB_CLK); t++; end
    opb_wr(32'h08, 32'd80);
    count_win(120, hi_c, lo_c, off_c, both_c);
    chk("t3_old_duty_holds", hi_c, 0);
    hi_pulse(len); chk("t3_blend_pulse", len, 105);
    hi_pulse(len); chk("t3_new_pulse", len, 155);

    // duty limits
    opb_wr(32'h08, 32'd0);
    repeat (400) @(negedge OPB_CLK);
    count_win(200, hi_c, lo_c, off_c, both_c);
    chk("t4_d0_hi", hi_c, 0);
    chk("t4_d0_lo", lo_c, 200);
    opb_wr(32'h08, 32'd100);
    repeat (400) @(negedge OPB_CLK);
    count_win(200, hi_c, lo_c, off_c, both_c);
    chk("t4_dp_hi", hi_c, 200);
    chk("t4_dp_lo", lo_c, 0);
    opb_wr(32'h02, 32'd8);
    opb_wr(32'h08, 32'd4);
    repeat (400) @(negedge OPB_CLK);
    count_win(200, hi_c, lo_c, off_c, both_c);
    chk("t4_short_hi", hi_c, 0);
    chk("t4_short_lo", lo_c, 184);

    // async reset mid-run
    t = 0;
    while (!pwm_lo_o[0] && t < 1000) begin @(negedge OPB_CLK); t++; end
    chk("t1_pre_lo", pwm_lo_o[0], 1);
    chk("t1_pre_en", en_o, 1);
    #2 OPB_RST_N = 1'b0;
    #1 chk("t1_async_outs", {16'(pwm_hi_o), 8'(pwm_lo_o), 6'd0, en_o, fault_o}, 32'h0);
    repeat (2) @(negedge OPB_CLK);
    OPB_RST_N = 1'b1;
    opb_rd(32'h04, rd); chk("t1_status", rd, 32'h0);
    opb_rd(32'h01, rd); chk("t1_period", rd, 32'h0);

    // fault
    opb_wr(32'h01, 32'd100);
    opb_wr(32'h08, 32'd30);
    opb_wr(32'h02, 32'd5);
    opb_wr(32'h00, 32'h1);
    opb_wr(32'h03, 32'h1);
    repeat (50) @(negedge OPB_CLK);
    chk("t5_pre_en", en_o, 1);
    fault_i = 2'b10;
    repeat (3) @(negedge OPB_CLK);
    chk("t5_outs_off", {16'(pwm_hi_o), 8'(pwm_lo_o), 7'd0, en_o}, 32'h0);
    chk("t5_fault_o", fault_o, 1);
    repeat (2) @(negedge OPB_CLK);
    fault_i = 2'b00;
    repeat (5) @(negedge OPB_CLK);
    opb_rd(32'h04, rd); chk("t5_status", rd, 32'h0202);
    opb_wr(32'h03, 32'h1);
    opb_rd(32'h04, rd); chk("t5_start_ignored", rd, 32'h0202);
    chk("t5_en_ignored", en_o, 0);
    opb_wr(32'h03, 32'h4);
    opb_rd(32'h04, rd); chk("t5_cleared", rd, 32'h0);
    opb_wr(32'h03, 32'h1);
    opb_rd(32'h04, rd); chk("t5_resume", rd, 32'h1);

    // stop beats start in the same write
    opb_wr(32'h03, 32'h3);
    opb_rd(32'h04, rd); chk("stop_in_run", rd, 32'h0);
    opb_wr(32'h03, 32'h3);
    opb_rd(32'h04, rd); chk("stop_wins_idle", rd, 32'h0);

    // timed test run: 16 periods of 20 cycles
    opb_wr(32'h01, 32'd10);
    opb_wr(32'h00, 32'h0101_0001);
    opb_rd(32'h00, rd); chk("t6_config_rd", rd, 32'h0101_0001);
    opb_wr(32'h03, 32'h1);
    len = 0;
    while (en_o && len < 2000) begin len++; @(negedge OPB_CLK); end
    chk("t6_run_cycles", len, 320);
    opb_rd(32'h04, rd); chk("t6_status", rd, 32'h0004);
    opb_wr(32'h03, 32'h1);
    opb_rd(32'h04, rd); chk("t6_done_cleared", rd, 32'h0001);
    opb_wr(32'h03, 32'h2);

    // period below 2 behaves as 2
    opb_wr(32'h00, 32'h1);
    opb_wr(32'h01, 32'd1);
    opb_wr(32'h08, 32'd1);
    opb_wr(32'h02, 32'd0);
    opb_wr(32'h03, 32'h1);
    repeat (20) @(negedge OPB_CLK);
    count_win(200, hi_c, lo_c, off_c, both_c);
    chk("pmin_hi", hi_c, 100);
    chk("pmin_lo", lo_c, 100);
    chk("pmin_gap", off_c, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
